// File: rtl/en_16_4_8_3_pkg.sv
// rtl/en_16_4_8_3_pkg.sv - shared widths for the 16-to-4 priority encoder
package en_16_4_8_3_pkg;
   localparam int IN_W      = 16;
   localparam int OUT_W     = 4;
   localparam int SUB_IN_W  = 8;
   localparam int SUB_OUT_W = 3;
endpackage

// File: rtl/en_16_4_8_3_enc_8_3.sv
// rtl/en_16_4_8_3_enc_8_3.sv - combinational 8-to-3 priority encoder, highest bit wins
module enc_8_3
   import en_16_4_8_3_pkg::*;
(
   input  logic [SUB_IN_W-1:0]  d,
   output logic [SUB_OUT_W-1:0] idx,
   output logic                 v
);

   // Ascending scan: the last set bit seen is the highest, so it wins.
   always_comb begin
      idx = '0;
      v   = 1'b0;
      for (int n = 0; n < SUB_IN_W; n++) begin
         if (d[n]) begin
            idx = SUB_OUT_W'(n);
            v   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/en_16_4_8_3.sv
// rtl/en_16_4_8_3.sv - registered 16-to-4 priority encoder built from two 8-to-3 encoders
module en_16_4_8_3
   import en_16_4_8_3_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  i,
   output logic [OUT_W-1:0] y,
   output logic             valid
);

   logic [SUB_OUT_W-1:0] lo_idx, hi_idx;
   logic                 lo_v, hi_v;
   logic [OUT_W-1:0]     y_d, y_q;
   logic                 valid_d, valid_q;

   enc_8_3 u_lo (
      .d   (i[SUB_IN_W-1:0]),
      .idx (lo_idx),
      .v   (lo_v)
   );

   enc_8_3 u_hi (
      .d   (i[IN_W-1:SUB_IN_W]),
      .idx (hi_idx),
      .v   (hi_v)
   );

   // Any upper-half request outranks the lower half and supplies the MSB.
   always_comb begin
      y_d     = {hi_v, (hi_v ? hi_idx : lo_idx)};
      valid_d = hi_v | lo_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign y     = y_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_en_16_4_8_3.sv
// tb/tb_en_16_4_8_3.sv - scoreboard bench for the registered 16-to-4 priority encoder
module tb_en_16_4_8_3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i   = 16'h0000;
   logic [3:0]  y;
   logic        valid;

   int checks = 0;
   int errors = 0;

   // expected {valid, y}
   logic [4:0] exp_q[$];

   en_16_4_8_3 dut (
      .clk   (clk),
      .rst   (rst),
      .i     (i),
      .y     (y),
      .valid (valid)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_enc(input logic [15:0] v);
      logic [4:0] r;
      r = 5'b0;
      for (int k = 15; k >= 0; k--) begin
         if (v[k]) begin
            r = {1'b1, 4'(k)};
            break;
         end
      end
      return r;
   endfunction

   task automatic drive(input logic [15:0] v, input logic r, input logic [4:0] e);
      @(negedge clk);
      i   = v;
      rst = r;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      logic [4:0] e;
      for (int c = 0; c < 2; c++) begin
         drive(16'hFFFF, 1'b1, 5'b0_0000);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            $display("FAIL reset c=%0d got valid=%b y=%h exp valid=%b y=%h", c, valid, y, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_walking_one();
      logic [4:0] e;
      for (int n = 0; n < 16; n++) begin
         drive(16'h0001 << n, 1'b0, {1'b1, 4'(n)});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            $display("FAIL walk n=%0d got valid=%b y=%h exp valid=%b y=%h", n, valid, y, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_zero_vs_index0();
      logic [15:0] vin [2] = '{16'h0000, 16'h0001};
      logic [4:0]  vexp[2] = '{5'b0_0000, 5'b1_0000};
      logic [4:0]  e;
      for (int c = 0; c < 2; c++) begin
         drive(vin[c], 1'b0, vexp[c]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            $display("FAIL zero_idx0 i=%h got valid=%b y=%h exp valid=%b y=%h", vin[c], valid, y, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_priority();
      logic [15:0] vin [3] = '{16'h8001, 16'h00FF, 16'h0180};
      logic [4:0]  vexp[3] = '{5'b1_1111, 5'b1_0111, 5'b1_1000};
      logic [4:0]  e;
      for (int c = 0; c < 3; c++) begin
         drive(vin[c], 1'b0, vexp[c]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            $display("FAIL priority i=%h got valid=%b y=%h exp valid=%b y=%h", vin[c], valid, y, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic       rin [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [4:0] vexp[4] = '{5'b1_1110, 5'b0_0000, 5'b1_1110, 5'b1_1110};
      logic [4:0] e;
      for (int c = 0; c < 4; c++) begin
         drive(16'h4000, rin[c], vexp[c]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            $display("FAIL mid_reset c=%0d got valid=%b y=%h exp valid=%b y=%h", c, valid, y, e[4], e[3:0]);
         end
      end
   endtask

   // Inputs change every cycle; the queue carries one expectation in flight.
   task automatic test_exhaustive();
      logic [4:0]  e;
      logic [15:0] v;
      int          bad = 0;
      for (int n = 0; n < 65536; n++) begin
         v = 16'(n);
         drive(v, 1'b0, ref_enc(v));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({valid, y} !== e) begin
            errors++;
            if (bad < 10)
               $display("FAIL exhaustive i=%h got valid=%b y=%h exp valid=%b y=%h", v, valid, y, e[4], e[3:0]);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_walking_one();
      test_zero_vs_index0();
      test_priority();
      test_mid_reset();
      test_exhaustive();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
